alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU with valid/ready handshakes on both sides. It replaces the

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_div_seq.sv | 66 ++++++
 rtl/alu_mc.sv | 188 ++++++++++++++++++
 tb/tb_alu_mc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_MUL  = 4'h2;
    localparam logic [3:0] ALU_DIV  = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_NAND = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_XOR  = 4'h8;
    localparam logic [3:0] ALU_XNOR = 4'h9;
    localparam logic [3:0] ALU_EQ   = 4'hA;
    localparam logic [3:0] ALU_GT   = 4'hB;
    localparam logic [3:0] ALU_LT   = 4'hC;
    localparam logic [3:0] ALU_SHR  = 4'hD;
    localparam logic [3:0] ALU_SHL  = 4'hE;

    localparam int unsigned FLG_ZERO    = 0;
    localparam int unsigned FLG_CARRY   = 1;
    localparam int unsigned FLG_DIV0    = 2;
    localparam int unsigned FLG_ILLEGAL = 3;
    localparam int unsigned FLG_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_div_seq.sv
// Restoring unsigned divider: one quotient bit per cycle for WIDTH cycles after start.
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic             w_last;

    // r_quo shifts dividend bits out of its MSB while quotient bits enter at the LSB
    always_comb begin
        w_trial = {r_rem, r_quo[WIDTH-1]};
        w_diff  = w_trial - {1'b0, r_dvs};
        w_ge    = (w_trial >= {1'b0, r_dvs});
        w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_dvs  <= i_divisor;
        end else if (r_busy) begin
            r_rem <= WIDTH'(w_ge ? w_diff : w_trial);
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done_c    = r_busy && w_last;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides and registered result/flags.
// Define ALU_DIV_EN to build the iterative divider; otherwise opcode 3 is reported as illegal.
module alu_mc
    import alu_pkg::*;
#(
    parameter  int unsigned OPER_WIDTH = 8,
    localparam int unsigned OUT_WIDTH  = 2 * OPER_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [OPER_WIDTH-1:0] i_a,
    input  logic [OPER_WIDTH-1:0] i_b,
    input  logic [3:0]            i_alu_fun,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [OUT_WIDTH-1:0]  o_alu_out,
    output logic [FLG_W-1:0]      o_flags
);

    logic                  r_out_valid;
    logic [OUT_WIDTH-1:0]  r_alu_out;
    logic [FLG_W-1:0]      r_flags;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_is_seq_div;
    logic                  w_load_op;
    logic                  w_load_div;
    logic [OUT_WIDTH-1:0]  w_res;
    logic [FLG_W-1:0]      w_flg;
    logic [OUT_WIDTH-1:0]  w_div_res;
    logic [FLG_W-1:0]      w_div_flg;
    logic [OUT_WIDTH-1:0]  w_a_ext;
    logic [OUT_WIDTH-1:0]  w_b_ext;
    logic [OPER_WIDTH-1:0] w_and;
    logic [OPER_WIDTH-1:0] w_or;
    logic [OPER_WIDTH-1:0] w_xor;
    logic [OPER_WIDTH-1:0] w_nand;
    logic [OPER_WIDTH-1:0] w_nor;
    logic [OPER_WIDTH-1:0] w_xnor;

    assign o_in_ready = w_idle && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_load_op  = w_accept && !w_is_seq_div;

`ifdef ALU_DIV_EN
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_div_busy;
    logic                  w_div_done_c;
    logic [OPER_WIDTH-1:0] w_div_quo;
    logic [OPER_WIDTH-1:0] w_div_rem;

    assign w_idle       = (r_state == IDLE);
    assign w_is_seq_div = (i_alu_fun == ALU_DIV) && (i_b != '0);

    alu_div_seq #(
        .WIDTH (OPER_WIDTH)
    ) u_div (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (w_accept && w_is_seq_div),
        .i_dividend  (i_a),
        .i_divisor   (i_b),
        .o_busy      (w_div_busy),
        .o_done_c    (w_div_done_c),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE holds the finished quotient until the output register is free
    always_comb begin
        w_state_nxt = r_state;
        w_load_div  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_seq_div) begin
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                if (w_div_done_c || !w_div_busy) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!r_out_valid || i_out_ready) begin
                    w_load_div  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_div_res            = {w_div_rem, w_div_quo};
        w_div_flg            = '0;
        w_div_flg[FLG_ZERO]  = (w_div_res == '0);
    end
`else
    assign w_idle       = 1'b1;
    assign w_is_seq_div = 1'b0;
    assign w_load_div   = 1'b0;
    assign w_div_res    = '0;
    assign w_div_flg    = '0;
`endif

    // Single-cycle operations, evaluated straight from the accepted operands
    always_comb begin
        w_a_ext = {{OPER_WIDTH{1'b0}}, i_a};
        w_b_ext = {{OPER_WIDTH{1'b0}}, i_b};
        w_and   = i_a & i_b;
        w_or    = i_a | i_b;
        w_xor   = i_a ^ i_b;
        w_nand  = ~w_and;
        w_nor   = ~w_or;
        w_xnor  = ~w_xor;
        w_res   = '0;
        w_flg   = '0;
        case (i_alu_fun)
            ALU_ADD: begin
                w_res            = w_a_ext + w_b_ext;
                w_flg[FLG_CARRY] = w_res[OPER_WIDTH];
            end
            ALU_SUB: begin
                w_res            = w_a_ext - w_b_ext;
                w_flg[FLG_CARRY] = (i_a < i_b);
            end
            ALU_MUL: w_res = w_a_ext * w_b_ext;
`ifdef ALU_DIV_EN
            ALU_DIV: begin
                w_res           = {i_a, {OPER_WIDTH{1'b1}}};
                w_flg[FLG_DIV0] = 1'b1;
            end
`else
            ALU_DIV: w_flg[FLG_ILLEGAL] = 1'b1;
`endif
            ALU_AND:  w_res = {{OPER_WIDTH{1'b0}}, w_and};
            ALU_OR:   w_res = {{OPER_WIDTH{1'b0}}, w_or};
            ALU_NAND: w_res = {{OPER_WIDTH{1'b0}}, w_nand};
            ALU_NOR:  w_res = {{OPER_WIDTH{1'b0}}, w_nor};
            ALU_XOR:  w_res = {{OPER_WIDTH{1'b0}}, w_xor};
            ALU_XNOR: w_res = {{OPER_WIDTH{1'b0}}, w_xnor};
            ALU_EQ:   w_res = (i_a == i_b) ? OUT_WIDTH'(1) : '0;
            ALU_GT:   w_res = (i_a > i_b) ? OUT_WIDTH'(2) : '0;
            ALU_LT:   w_res = (i_a < i_b) ? OUT_WIDTH'(3) : '0;
            ALU_SHR:  w_res = w_a_ext >> 1;
            ALU_SHL:  w_res = w_a_ext << 1;
            default:  w_flg[FLG_ILLEGAL] = 1'b1;
        endcase
        w_flg[FLG_ZERO] = (w_res == '0);
    end

    // Output register: a new load wins over a take so back-to-back ops stream
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_flags     <= '0;
        end else if (w_load_op) begin
            r_out_valid <= 1'b1;
            r_alu_out   <= w_res;
            r_flags     <= w_flg;
        end else if (w_load_div) begin
            r_out_valid <= 1'b1;
            r_alu_out   <= w_div_res;
            r_flags     <= w_div_flg;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_alu_out   = r_alu_out;
    assign o_flags     = r_flags;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus random traffic against a behavioural model.
module tb_alu_mc;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_in_valid;
    logic           o_in_ready;
    logic [W-1:0]   i_a;
    logic [W-1:0]   i_b;
    logic [3:0]     i_alu_fun;
    logic           o_out_valid;
    logic           i_out_ready;
    logic [2*W-1:0] o_alu_out;
    logic [3:0]     o_flags;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    bit m_ov   = 1'b0;
    int m_out  = 0;
    int m_flg  = 0;
    int m_busy = 0;
    int m_div_out = 0;
    int m_div_flg = 0;

    always #5 clk = ~clk;

    alu_mc #(.OPER_WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_alu_fun   (i_alu_fun),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_alu_out   (o_alu_out),
        .o_flags     (o_flags)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Result and {ILLEGAL,DIV0,CARRY,ZERO} straight from the opcode definitions
    function automatic void ref_op(input int op, input int a, input int b,
                                   output int res, output int flg);
        bit ill = 1'b0;
        bit d0  = 1'b0;
        bit cy  = 1'b0;
        res = 0;
        case (op)
            0: begin res = a + b; cy = (res > MASK); end
            1: begin res = (a - b) & ((1 << (2*W)) - 1); cy = (a < b); end
            2: res = a * b;
            3: begin
                if (!DIV_EN) ill = 1'b1;
                else if (b == 0) begin res = a * (MASK + 1) + MASK; d0 = 1'b1; end
                else res = (a % b) * (MASK + 1) + (a / b);
            end
            4: res = a & b;
            5: res = a | b;
            6: res = MASK - (a & b);
            7: res = MASK - (a | b);
            8: res = a ^ b;
            9: res = MASK - (a ^ b);
            10: res = (a == b) ? 1 : 0;
            11: res = (a > b) ? 2 : 0;
            12: res = (a < b) ? 3 : 0;
            13: res = a / 2;
            14: res = a * 2;
            default: ill = 1'b1;
        endcase
        flg = (ill ? 8 : 0) + (d0 ? 4 : 0) + (cy ? 2 : 0) + ((res == 0) ? 1 : 0);
    endfunction

    // Model: a divide keeps the block busy W+1 cycles, everything else lands next cycle
    always @(posedge clk or negedge rst_n) begin : model
        int  res, flg;
        bit  rdy, acc, sdiv, ld_div;
        if (!rst_n) begin
            m_ov   <= 1'b0;
            m_out  <= 0;
            m_flg  <= 0;
            m_busy <= 0;
        end else begin
            rdy    = (m_busy == 0) && (!m_ov || i_out_ready);
            acc    = i_in_valid && rdy;
            sdiv   = DIV_EN && (i_alu_fun == 4'd3) && (i_b != 0);
            ld_div = (m_busy == 1) && (!m_ov || i_out_ready);
            ref_op(int'(i_alu_fun), int'(i_a), int'(i_b), res, flg);
            if (ld_div) begin
                m_ov <= 1'b1; m_out <= m_div_out; m_flg <= m_div_flg;
            end else if (acc && !sdiv) begin
                m_ov <= 1'b1; m_out <= res; m_flg <= flg;
            end else if (m_ov && i_out_ready) begin
                m_ov <= 1'b0;
            end
            if (acc && sdiv) begin
                m_busy <= W + 1; m_div_out <= res; m_div_flg <= flg;
            end else if (m_busy > 1) begin
                m_busy <= m_busy - 1;
            end else if (ld_div) begin
                m_busy <= 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit exp_rdy;
        if (rst_n) begin
            exp_rdy = (m_busy == 0) && (!m_ov || i_out_ready);
            chk("in_ready", int'(o_in_ready), int'(exp_rdy));
            chk("out_valid", int'(o_out_valid), int'(m_ov));
            if (m_ov) begin
                chk("alu_out", int'(o_alu_out), m_out);
                chk("flags", int'(o_flags), m_flg);
            end
        end
    end

    task automatic send(input int a, input int b, input int op, output int waited);
        bit acc;
        waited = 0;
        acc = 1'b0;
        i_a = W'(a); i_b = W'(b); i_alu_fun = 4'(op); i_in_valid = 1'b1;
        while (!acc && waited < 64) begin
            @(negedge clk);
            acc = o_in_ready;
            @(posedge clk);
            waited++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        #2;
        i_in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input int out, input int flg);
        chk({nm, "_valid"}, int'(o_out_valid), 1);
        chk({nm, "_out"}, int'(o_alu_out), out);
        chk({nm, "_flags"}, int'(o_flags), flg);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        int r, f, n;
        rst_n = 1'b0; i_in_valid = 1'b0; i_a = '0; i_b = '0; i_alu_fun = '0; i_out_ready = 1'b1;

        ref_op(0, 200, 100, r, f);   chk("pin_add", r, 'h012C); chk("pin_add_f", f, 'h2);
        ref_op(1, 5, 9, r, f);       chk("pin_sub", r, 'hFFFC); chk("pin_sub_f", f, 'h2);
        ref_op(9, 'hAA, 'h0F, r, f); chk("pin_xnor", r, 'h5A);
        ref_op(14, 'h81, 0, r, f);   chk("pin_shl", r, 'h102);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out", int'(o_alu_out), 0);
        chk("rst_flags", int'(o_flags), 0);
        chk("rst_valid", int'(o_out_valid), 0);
        chk("rst_ready", int'(o_in_ready), 1);

        send(200, 100, 0, n); @(negedge clk); expect_out("add", 'h012C, 'h2);
        send(5, 9, 1, n);     @(negedge clk); expect_out("sub", 'hFFFC, 'h2);

        send(100, 7, 3, n);
`ifdef ALU_DIV_EN
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            chk("div_in_ready_low", int'(o_in_ready), 0);
        end
        @(negedge clk); expect_out("div", 'h020E, 'h0);
        send(5, 0, 3, n); @(negedge clk); expect_out("div0", 'h05FF, 'h4);
`else
        @(negedge clk); expect_out("div_off", 0, 'h9);
        send(5, 0, 3, n); @(negedge clk); expect_out("div0_off", 0, 'h9);
`endif

        @(posedge clk); #2;
        send(16, 16, 2, n);
        i_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_out", int'(o_alu_out), 'h0100);
            chk("bp_in_ready", int'(o_in_ready), 0);
        end
        @(posedge clk); #2;
        i_out_ready = 1'b1;
        send(3, 4, 0, n);
        chk("bp_same_cycle_accept", n, 1);
        @(negedge clk); expect_out("bp_next", 7, 0);

        @(posedge clk); #2;
        send(100, 7, 3, n);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", int'(o_alu_out), 0);
        chk("mid_rst_flags", int'(o_flags), 0);
        chk("mid_rst_valid", int'(o_out_valid), 0);
        chk("mid_rst_ready", int'(o_in_ready), 1);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            i_in_valid  = ($urandom_range(9) < 7);
            i_out_ready = ($urandom_range(9) < 7);
            i_alu_fun   = 4'($urandom_range(15));
            i_a         = W'($urandom);
            case ($urandom_range(5))
                0:       i_b = '0;
                1:       i_b = i_a;
                default: i_b = W'($urandom);
            endcase
        end
        @(posedge clk); #2;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
